event_blinker: RTL and testbench

//   Output-side counterpart of the button debouncer. It turns single-cycle internal event pulses

---
 rtl/event_blinker_pkg.sv | 24 ++
 rtl/event_blinker_phase_timer.sv | 29 ++
 rtl/event_blinker.sv | 126 ++++++++++++
 tb/tb_event_blinker.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/event_blinker_pkg.sv
// Shared types and default timing constants for the event blinker.
package event_blinker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

  // Short phases for simulation, long phases for a visible blink on a ~50 MHz board clock.
  localparam int unsigned SimOnCycles    = 4;
  localparam int unsigned SimOffCycles   = 2;
  localparam int unsigned BoardOnCycles  = 5_000_000;
  localparam int unsigned BoardOffCycles = 5_000_000;
  localparam int unsigned DefPendW       = 2;

  // Phase counter width: must hold the longer of the two phase lengths.
  function automatic int unsigned phase_width(input int unsigned on_c, input int unsigned off_c);
    int unsigned m;
    m = (on_c > off_c) ? on_c : off_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/event_blinker_phase_timer.sv
// Loadable down-counter timing one ON or OFF phase; done flags the final cycle of a phase.
module phase_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] value_o,
  output logic             done_o
);

  logic [Width-1:0] value_q;

  // Holds at zero once expired rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (value_q != '0) begin
      value_q <= value_q - 1'b1;
    end
  end

  assign value_o = value_q;
  assign done_o  = (value_q == Width'(1));

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle event pulses into ON/OFF LED blinks, queueing pulses seen mid-blink.
// Optional BLINK_OVERFLOW_EN builds a sticky flag for events dropped at a full queue.
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = SimOnCycles,
  parameter int unsigned OFF_CYCLES = SimOffCycles,
  parameter int unsigned PEND_W     = DefPendW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned TW = phase_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [PEND_W-1:0] PendMax = '1;

  state_e            state_q, state_d;
  logic              led_q, led_d, busy_q;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              tmr_load, tmr_done;
  logic [TW-1:0]     tmr_load_val, tmr_value;
  logic              start_next, inc, dec;

  phase_timer #(
    .Width(TW)
  ) u_phase_timer (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = TW'(ON_CYCLES);
    start_next   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pulse_in) begin
          state_d  = S_ON;
          tmr_load = 1'b1;
        end
      end
      S_ON: begin
        if (tmr_done) begin
          state_d      = S_OFF;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(OFF_CYCLES);
        end
      end
      S_OFF: begin
        // A pulse on the last OFF edge with an empty queue is started directly (inc+dec).
        if (tmr_done) begin
          start_next = (pend_q != '0) || pulse_in;
          state_d    = start_next ? S_ON : S_IDLE;
          tmr_load   = start_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inc = pulse_in && (state_q != S_IDLE);
  assign dec = start_next;

  always_comb begin
    pend_d = pend_q;
    if (inc && !dec && (pend_q != PendMax)) begin
      pend_d = pend_q + 1'b1;
    end else if (dec && !inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  assign led_d = (state_d == S_ON);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      busy_q  <= (state_d != S_IDLE);
      pend_q  <= pend_d;
    end
  end

`ifdef BLINK_OVERFLOW_EN
  logic ovf_q;
  logic drop;

  assign drop = inc && !dec && (pend_q == PendMax);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  // An idle blinker always has an expired phase counter.
  idle_timer_clear: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == S_IDLE) |-> (tmr_value == '0));

  assign led_out = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_event_blinker.sv
// Directed, table-driven bench for event_blinker at ON=4, OFF=2, PEND_W=2.
module tb_event_blinker;

  localparam int unsigned OnC   = 4;
  localparam int unsigned OffC  = 2;
  localparam int unsigned PendW = 2;
`ifdef BLINK_OVERFLOW_EN
  localparam int OvfExp = 1;
`else
  localparam int OvfExp = 0;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             pulse_in = 1'b0;
  logic             led_out;
  logic             busy;
  logic [PendW-1:0] pending;
  logic             overflow;

  always #5 clk = ~clk;

  event_blinker #(
    .ON_CYCLES  (OnC),
    .OFF_CYCLES (OffC),
    .PEND_W     (PendW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  typedef struct {
    logic       p;
    logic       led;
    logic       busy;
    logic [1:0] pend;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic led, input logic bsy, input logic [1:0] pend);
    vec_t v;
    v.p    = p;
    v.led  = led;
    v.busy = bsy;
    v.pend = pend;
    vecs.push_back(v);
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic step(input logic p);
    @(negedge clk);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int first, input int last, input int ovf_exp);
    for (int i = first; i <= last; i++) begin
      step(vecs[i].p);
      chk("led", i, int'(led_out), int'(vecs[i].led));
      chk("busy", i, int'(busy), int'(vecs[i].busy));
      chk("pend", i, int'(pending), int'(vecs[i].pend));
      chk("ovf", i, int'(overflow), ovf_exp);
    end
  endtask

  initial begin
    int   blinks;
    int   n;
    logic prev_led;

    // Scenario 1: rows 0..6
    add(1, 1, 1, 0); add(0, 1, 1, 0); add(0, 1, 1, 0); add(0, 1, 1, 0);
    add(0, 0, 1, 0); add(0, 0, 1, 0); add(0, 0, 0, 0);
    // Scenario 2: rows 7..19
    add(1, 1, 1, 0); add(1, 1, 1, 1); add(0, 1, 1, 1); add(0, 1, 1, 1);
    add(0, 0, 1, 1); add(0, 0, 1, 1); add(0, 1, 1, 0); add(0, 1, 1, 0);
    add(0, 1, 1, 0); add(0, 1, 1, 0); add(0, 0, 1, 0); add(0, 0, 1, 0);
    add(0, 0, 0, 0);
    // Scenario 4: pulse on the last OFF edge with pending=1, rows 20..38
    add(1, 1, 1, 0); add(1, 1, 1, 1); add(0, 1, 1, 1); add(0, 1, 1, 1);
    add(0, 0, 1, 1); add(0, 0, 1, 1); add(1, 1, 1, 1); add(0, 1, 1, 1);
    add(0, 1, 1, 1); add(0, 1, 1, 1); add(0, 0, 1, 1); add(0, 0, 1, 1);
    add(0, 1, 1, 0); add(0, 1, 1, 0); add(0, 1, 1, 0); add(0, 1, 1, 0);
    add(0, 0, 1, 0); add(0, 0, 1, 0); add(0, 0, 0, 0);

    // Reset state, before any clock edge is released.
    #12;
    chk("rst_led", 0, int'(led_out), 0);
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_pend", 0, int'(pending), 0);
    chk("rst_ovf", 0, int'(overflow), 0);
    @(negedge clk);
    resetn = 1'b1;
    step(0);

    run_rows(0, vecs.size() - 1, 0);

    // Scenario 3: five back-to-back pulses saturate the queue and drop one event.
    blinks   = 0;
    prev_led = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (led_out && !prev_led) blinks++;
      prev_led = led_out;
      chk("s3_pend", i, int'(pending), (i < 3) ? i : 3);
    end
    chk("s3_ovf", 0, int'(overflow), OvfExp);
    n = 0;
    while (busy && n < 100) begin
      step(0);
      n++;
      if (led_out && !prev_led) blinks++;
      prev_led = led_out;
      if (overflow !== 1'(OvfExp)) chk("s3_ovf_hold", n, int'(overflow), OvfExp);
    end
    chk("s3_busy_timeout", 0, int'(busy), 0);
    chk("s3_idle_edge", 0, n, 20);
    chk("s3_blinks", 0, blinks, 4);
    chk("s3_ovf_end", 0, int'(overflow), OvfExp);
    chk("s3_pend_end", 0, int'(pending), 0);

    // Scenario 5: asynchronous reset mid-ON with pending=2.
    step(1); step(1); step(1);
    chk("s5_pend_pre", 0, int'(pending), 2);
    chk("s5_led_pre", 0, int'(led_out), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("s5_led", 0, int'(led_out), 0);
    chk("s5_pend", 0, int'(pending), 0);
    chk("s5_busy", 0, int'(busy), 0);
    chk("s5_ovf", 0, int'(overflow), 0);
    @(negedge clk);
    pulse_in = 1'b0;
    resetn   = 1'b1;
    step(0);
    run_rows(0, 6, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
